// File: rtl/mmio_bus_ctrl.sv
// Load/store bus controller for the core: decodes memory vs. memory-mapped IO,
// runs a multi-cycle memory FSM, and owns the IO channel registers.
// Optional feature macro: MMIO_READBACK_EN (loads from offset 0x4 return io_out[k]).
module mmio_bus_ctrl #(
  parameter int DATA_W  = 32,
  parameter int IO_W    = 16,
  parameter int N_IO    = 4,
  parameter int MEM_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   req_ready,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [31:0]            mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic [N_IO*IO_W-1:0]   io_in,
  output logic [N_IO*IO_W-1:0]   io_out,
  output logic [N_IO-1:0]        io_wr_strobe,
  output logic                   err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_ACC  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_LAT - 1);
  localparam logic [4:0] N_IO_L    = 5'(N_IO);

  state_t            state;
  state_t            state_next;
  logic [2:0]        wait_cnt;
  logic              wait_done;
  logic              lat_we;

  logic              accept;
  logic              is_io;
  logic              io_mapped;
  logic [3:0]        ch_idx;
  logic [1:0]        reg_sel;
  logic              sel_out;
  logic              io_wr_hit;
  logic [N_IO-1:0]   wr_onehot;
  logic [IO_W-1:0]   io_rdata;

  logic [N_IO*IO_W-1:0] sync_q1;
  logic [N_IO*IO_W-1:0] sync_q2;
  logic [IO_W-1:0]      io_reg [N_IO];

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign is_io     = &req_addr[31:10];
  assign ch_idx    = req_addr[7:4];
  assign reg_sel   = req_addr[3:2];
  assign sel_out   = reg_sel[0];
  assign io_mapped = ({1'b0, ch_idx} < N_IO_L) && (req_addr[9:8] == 2'b00) && !reg_sel[1];

  assign accept    = req_valid && req_ready;
  assign io_wr_hit = accept && is_io && io_mapped && req_we && sel_out;
  assign wait_done = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking (<=) so all flops update from
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == MEM_WAIT) ? wait_cnt + 3'd1 : 3'd0;
    end
  end

  // FSM: next-state logic
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (accept && !is_io) state_next = MEM_ACC;
      MEM_ACC:  state_next = MEM_WAIT;
      MEM_WAIT: if (wait_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      IDLE:     req_ready = 1'b1;
      MEM_ACC: begin
        mem_en = 1'b1;
        mem_we = lat_we;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory request latch: held from MEM_ACC through the end of MEM_WAIT
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      lat_we    <= 1'b0;
    end else if (accept && !is_io) begin
      mem_addr  <= req_addr;
      mem_wdata <= req_wdata;
      lat_we    <= req_we;
    end
  end

  // ---------------------------------------------------------------------------
  // IO input synchronisers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= io_in;
      sync_q2 <= sync_q1;
    end
  end

  // ---------------------------------------------------------------------------
  // IO output registers
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_onehot = '0;
    for (int ch = 0; ch < N_IO; ch++) begin
      wr_onehot[ch] = io_wr_hit && (ch_idx == 4'(ch));
    end
  end

  // NOTE: this small register bank drives pins and must come out of reset at 0,
  // so it is cleared element by element; a true RAM array would be left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < N_IO; ch++) io_reg[ch] <= '0;
    end else begin
      for (int ch = 0; ch < N_IO; ch++) begin
        if (wr_onehot[ch]) io_reg[ch] <= req_wdata[IO_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < N_IO; g++) begin : g_io_out
    assign io_out[g*IO_W +: IO_W] = io_reg[g];
  end

  // Read mux: offset 0x0 is the synchronised input; 0x4 reads back only if enabled
  always_comb begin
    io_rdata = '0;
    for (int ch = 0; ch < N_IO; ch++) begin
      if (ch_idx == 4'(ch)) begin
        if (!sel_out) begin
          io_rdata = sync_q2[ch*IO_W +: IO_W];
        end
`ifdef MMIO_READBACK_EN
        else begin
          io_rdata = io_reg[ch];
        end
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response path: IO answers one cycle after accept, memory on the last wait cycle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      err          <= 1'b0;
      io_wr_strobe <= '0;
    end else begin
      rsp_valid    <= 1'b0;
      err          <= 1'b0;
      io_wr_strobe <= wr_onehot;
      if (accept && is_io) begin
        rsp_valid <= 1'b1;
        err       <= !io_mapped;
        rsp_rdata <= (io_mapped && !req_we) ? DATA_W'(io_rdata) : '0;
      end else if (wait_done) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= lat_we ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed self-checking bench for mmio_bus_ctrl (default parameters, MEM_LAT = 1).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmio_bus_ctrl;

  localparam int DATA_W = 32;
  localparam int IO_W   = 16;
  localparam int N_IO   = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [DATA_W-1:0]    req_wdata;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [DATA_W-1:0]    rsp_rdata;
  logic                 mem_en;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    mem_rdata = '0;
  logic [N_IO*IO_W-1:0] io_in;
  logic [N_IO*IO_W-1:0] io_out;
  logic [N_IO-1:0]      io_wr_strobe;
  logic                 err;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_io = '0;
  logic [31:0] exp_rb;
  logic [31:0] mem_model [64];

  mmio_bus_ctrl #(.DATA_W(DATA_W), .IO_W(IO_W), .N_IO(N_IO), .MEM_LAT(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_wr_strobe (io_wr_strobe),
    .err          (err)
  );

  always #5 clk = ~clk;

  // Synchronous data memory with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr[7:2]];
    end
  end

  // Called on a falling edge; returns on the falling edge of cycle 1 after accept.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; io_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready c%0d: got %b exp 1", c, req_ready); end
      tests++; if (io_out !== 64'h0) begin fails++; $display("FAIL reset_io_out c%0d: got %h exp 0", c, io_out); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid c%0d: got %b exp 0", c, rsp_valid); end
      tests++; if (mem_en !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL reset_mem_en_err c%0d: got %b%b exp 00", c, mem_en, err); end
    end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h exp 0", rsp_rdata); end
  endtask

  task automatic test_io_store();
    issue(1'b1, 32'hFFFF_FC14, 32'h0000_A5A5);
    exp_io[31:16] = 16'hA5A5;
    tests++; if (io_wr_strobe !== 4'b0010) begin fails++; $display("FAIL store_strobe: got %b exp 0010", io_wr_strobe); end
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL store_rsp_valid: got %b exp 1", rsp_valid); end
    tests++; if (io_out !== exp_io) begin fails++; $display("FAIL store_io_out: got %h exp %h", io_out, exp_io); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL store_err: got %b exp 0", err); end
    @(negedge clk);
    tests++; if (io_wr_strobe !== 4'b0000 || rsp_valid !== 1'b0) begin fails++; $display("FAIL store_pulse_end: got %b/%b exp 0000/0", io_wr_strobe, rsp_valid); end
  endtask

  task automatic test_io_load();
    io_in = 64'h0000_5678_0000_1234;
    @(negedge clk);
    @(negedge clk);
    issue(1'b0, 32'hFFFF_FC00, 32'h0);
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL load_ch0_valid: got %b exp 1", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h0000_1234) begin fails++; $display("FAIL load_ch0_data: got %h exp 00001234", rsp_rdata); end
    issue(1'b0, 32'hFFFF_FC23, 32'h0);
    tests++; if (rsp_rdata !== 32'h0000_5678) begin fails++; $display("FAIL load_ch2_lowbits: got %h exp 00005678", rsp_rdata); end
    // Pin change: reads accepted one and two edges later still see the old value
    io_in[15:0] = 16'hBEEF;
    issue(1'b0, 32'hFFFF_FC00, 32'h0);
    tests++; if (rsp_rdata !== 32'h0000_1234) begin fails++; $display("FAIL sync_edge1: got %h exp 00001234", rsp_rdata); end
    issue(1'b0, 32'hFFFF_FC00, 32'h0);
    tests++; if (rsp_rdata !== 32'h0000_1234) begin fails++; $display("FAIL sync_edge2: got %h exp 00001234", rsp_rdata); end
    issue(1'b0, 32'hFFFF_FC00, 32'h0);
    tests++; if (rsp_rdata !== 32'h0000_BEEF) begin fails++; $display("FAIL sync_edge3: got %h exp 0000beef", rsp_rdata); end
  endtask

  task automatic test_mem_load();
    issue(1'b0, 32'h0000_0040, 32'h0);
    tests++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin fails++; $display("FAIL mem_c1_en_we: got %b%b exp 10", mem_en, mem_we); end
    tests++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL mem_c1_ready_valid: got %b%b exp 00", req_ready, rsp_valid); end
    tests++; if (mem_addr !== 32'h0000_0040) begin fails++; $display("FAIL mem_c1_addr: got %h exp 00000040", mem_addr); end
    @(negedge clk);
    tests++; if (mem_en !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL mem_c2_en_ready_valid: got %b%b%b exp 000", mem_en, req_ready, rsp_valid); end
    tests++; if (mem_addr !== 32'h0000_0040) begin fails++; $display("FAIL mem_c2_addr_hold: got %h exp 00000040", mem_addr); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || req_ready !== 1'b1) begin fails++; $display("FAIL mem_c3_valid_ready: got %b%b exp 11", rsp_valid, req_ready); end
    tests++; if (rsp_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL mem_c3_data: got %h exp deadbeef", rsp_rdata); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL mem_c4_valid: got %b exp 0", rsp_valid); end
  endtask

  task automatic test_unmapped();
    issue(1'b0, 32'hFFFF_FC40, 32'h0);
    tests++; if (err !== 1'b1 || rsp_valid !== 1'b1) begin fails++; $display("FAIL unmap_ch4_err_valid: got %b%b exp 11", err, rsp_valid); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL unmap_ch4_data: got %h exp 0", rsp_rdata); end
    issue(1'b1, 32'hFFFF_FC18, 32'h0000_FFFF);
    tests++; if (err !== 1'b1 || io_wr_strobe !== 4'b0) begin fails++; $display("FAIL unmap_off8: got err %b strobe %b exp 1/0000", err, io_wr_strobe); end
    tests++; if (io_out !== exp_io) begin fails++; $display("FAIL unmap_off8_io_out: got %h exp %h", io_out, exp_io); end
    issue(1'b0, 32'hFFFF_FD04, 32'h0);
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL unmap_bit8: got %b exp 1", err); end
    issue(1'b1, 32'hFFFF_FC10, 32'h0000_5555);
    tests++; if (err !== 1'b0 || rsp_valid !== 1'b1 || io_wr_strobe !== 4'b0) begin fails++; $display("FAIL store_inreg: got err %b valid %b strobe %b exp 0/1/0000", err, rsp_valid, io_wr_strobe); end
    tests++; if (io_out !== exp_io) begin fails++; $display("FAIL store_inreg_io_out: got %h exp %h", io_out, exp_io); end
  endtask

  task automatic test_readback();
`ifdef MMIO_READBACK_EN
    exp_rb = 32'h0000_A5A5;
`else
    exp_rb = 32'h0;
`endif
    issue(1'b0, 32'hFFFF_FC14, 32'h0);
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rb) begin fails++; $display("FAIL readback: got %b/%h exp 1/%h", rsp_valid, rsp_rdata, exp_rb); end
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 32'hFFFF_FC04, 32'h0000_1111);
    tests++; if (io_wr_strobe !== 4'b0001 || io_out[15:0] !== 16'h1111) begin fails++; $display("FAIL b2b_first: got %b/%h exp 0001/1111", io_wr_strobe, io_out[15:0]); end
    issue(1'b1, 32'hFFFF_FC04, 32'h0000_2222);
    exp_io[15:0] = 16'h2222;
    tests++; if (io_wr_strobe !== 4'b0001 || rsp_valid !== 1'b1) begin fails++; $display("FAIL b2b_second_pulse: got %b/%b exp 0001/1", io_wr_strobe, rsp_valid); end
    tests++; if (io_out !== exp_io) begin fails++; $display("FAIL b2b_last_wins: got %h exp %h", io_out, exp_io); end
    @(negedge clk);
    tests++; if (io_wr_strobe !== 4'b0000) begin fails++; $display("FAIL b2b_strobe_end: got %b exp 0000", io_wr_strobe); end
  endtask

  task automatic test_mem_store();
    issue(1'b1, 32'h0000_0080, 32'h1234_5678);
    tests++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678) begin fails++; $display("FAIL mstore_c1: got %b%b %h exp 11 12345678", mem_en, mem_we, mem_wdata); end
    // Request offered while busy must wait, then be taken in the response cycle
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hFFFF_FC34; req_wdata = 32'h0000_0077;
    @(negedge clk);
    tests++; if (req_ready !== 1'b0 || mem_addr !== 32'h80 || mem_wdata !== 32'h1234_5678) begin fails++; $display("FAIL mstore_c2_hold: got %b %h %h exp 0 00000080 12345678", req_ready, mem_addr, mem_wdata); end
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || io_wr_strobe !== 4'b0) begin fails++; $display("FAIL mstore_c3: got %b %h %b exp 1 0 0000", rsp_valid, rsp_rdata, io_wr_strobe); end
    @(negedge clk);
    req_valid = 1'b0;
    exp_io[63:48] = 16'h0077;
    tests++; if (io_wr_strobe !== 4'b1000 || rsp_valid !== 1'b1) begin fails++; $display("FAIL accept_in_rsp_cycle: got %b/%b exp 1000/1", io_wr_strobe, rsp_valid); end
    tests++; if (io_out !== exp_io) begin fails++; $display("FAIL accept_in_rsp_io_out: got %h exp %h", io_out, exp_io); end
    issue(1'b0, 32'h0000_0080, 32'h0);
    @(negedge clk);
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678) begin fails++; $display("FAIL mstore_readback: got %b/%h exp 1/12345678", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, 32'h0000_0040, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_io = '0;
    tests++; if (rsp_valid !== 1'b0 || mem_en !== 1'b0) begin fails++; $display("FAIL rst_mid_valid_en: got %b%b exp 00", rsp_valid, mem_en); end
    tests++; if (req_ready !== 1'b1 || io_out !== exp_io) begin fails++; $display("FAIL rst_mid_idle_io: got %b %h exp 1 %h", req_ready, io_out, exp_io); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_after: got %b%b exp 01", rsp_valid, req_ready); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_model[i] = '0;
    mem_model[16] = 32'hDEAD_BEEF;
    test_reset();
    test_io_store();
    test_io_load();
    test_mem_load();
    test_unmapped();
    test_readback();
    test_back_to_back();
    test_mem_store();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
